// File: rtl/serial_deserializer.sv
// Serial-to-parallel byte assembler: captures one bit per write_in rising edge (LSB first),
// presents the byte until acknowledged, and discards a stale partial byte after an idle timeout.
module serial_deserializer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clock_1MHz,
    input  logic       rst,
    input  logic       data_in,
    input  logic       write_in,
    input  logic       ack_in,
    output logic       status_out,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       timeout_out
);

    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        COLLECT  = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                write_q;
    logic                bit_edge;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_next;
    logic [BYTE_W-1:0]   shift_reg;
    logic [BYTE_W-1:0]   shift_next;
    logic [BYTE_W-1:0]   data_next;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_next;
    logic                timeout_next;

    // Strobe is level-held for many cycles; only its rising edge carries a bit.
    assign bit_edge = write_in & ~write_q;

    // State and datapath registers.
    always_ff @(posedge clock_1MHz) begin
        if (rst) begin
            state       <= COLLECT;
            write_q     <= 1'b0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            idle_cnt    <= '0;
            data_out    <= '0;
            timeout_out <= 1'b0;
            status_out  <= 1'b1;
            data_valid  <= 1'b0;
        end else begin
            state       <= state_next;
            write_q     <= write_in;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            idle_cnt    <= idle_next;
            data_out    <= data_next;
            timeout_out <= timeout_next;
            status_out  <= (state_next == COLLECT);
            data_valid  <= (state_next == WAIT_ACK);
        end
    end

    // Next-state and datapath update; an edge wins over a coincident timeout.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        data_next    = data_out;
        idle_next    = idle_cnt;
        timeout_next = 1'b0;

        case (state)
            COLLECT: begin
                if (bit_edge) begin
                    shift_next[bit_cnt] = data_in;
                    idle_next           = '0;
                    if (bit_cnt == CNT_W'(7)) begin
                        data_next    = {data_in, shift_reg[6:0]};
                        bit_cnt_next = '0;
                        state_next   = WAIT_ACK;
                    end else begin
                        bit_cnt_next = bit_cnt + CNT_W'(1);
                    end
                end else if (bit_cnt == '0) begin
                    idle_next = '0;
                end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES)) begin
                    bit_cnt_next = '0;
                    idle_next    = '0;
                    timeout_next = 1'b1;
                end else begin
                    idle_next = idle_cnt + IDLE_W'(1);
                end
            end
            WAIT_ACK: begin
                // Bits arriving while a byte is pending are dropped.
                idle_next = '0;
                if (ack_in) begin
                    state_next = COLLECT;
                end
            end
        endcase
    end

endmodule
